// File: rtl/pcg_arb_pkg.sv
// Shared types and helpers for the PCG RAM access arbiter: CPU FSM states,
// plane codes, per-plane write enables and byte-lane selection of {G, R, B}.
package pcg_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PEND  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } cpu_state_t;

    typedef enum logic [1:0] {
        PLANE_NONE = 2'b00,
        PLANE_B    = 2'b01,
        PLANE_R    = 2'b10,
        PLANE_G    = 2'b11
    } plane_t;

    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_B    = 3'b001;
    localparam logic [2:0] WE_R    = 3'b010;
    localparam logic [2:0] WE_G    = 3'b100;

    function automatic logic [2:0] plane_we(input plane_t plane);
        case (plane)
            PLANE_B: return WE_B;
            PLANE_R: return WE_R;
            PLANE_G: return WE_G;
            default: return WE_NONE;
        endcase
    endfunction

    // RAM word is packed {G, R, B}; an unselected plane reads as all ones.
    function automatic logic [7:0] lane_sel(input logic [23:0] q, input plane_t plane);
        case (plane)
            PLANE_B: return q[7:0];
            PLANE_R: return q[15:8];
            PLANE_G: return q[23:16];
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/pcg_cpu_fsm.sv
// CPU side of the PCG arbiter: operand latches, access FSM, wait generation,
// read-data register and starvation monitor.
module pcg_cpu_fsm
    import pcg_arb_pkg::*;
#(
    parameter int STARVE_MAX = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cg_cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  a_plane,
    input  logic [10:0] caddr,
    input  logic [7:0]  di,
    input  logic        vreq,
    input  logic [23:0] ram_q,
    output logic [7:0]  cpu_do,
    output logic        cg_wait_n,
    output logic        starve,
    output logic        issue,
    output logic [2:0]  issue_we,
    output logic [10:0] issue_addr,
    output logic [7:0]  issue_data
);

    cpu_state_t        state_reg, state_next;
    plane_t            plane_reg;
    logic              wr_reg;
    logic [10:0]       caddr_reg;
    logic [7:0]        di_reg;
    logic [7:0]        do_reg, do_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              starve_reg, starve_next;
    logic              cpu_req;

    assign cpu_req = cg_cs & (rd | wr);

    always_comb begin
        state_next = state_reg;
        do_next    = do_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (cpu_req) begin
                    if (plane_t'(a_plane) == PLANE_NONE) begin
                        state_next = ST_DONE;
                        if (!wr) do_next = 8'hFF;
                    end else begin
                        state_next = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!cg_cs)
                    state_next = ST_IDLE;
                else if (!vreq)
                    state_next = ST_ISSUE;
                else if (cnt_reg != CNT_W'(STARVE_MAX))
                    cnt_next = cnt_reg + 1'b1;
            end
            ST_ISSUE: begin
                // A video request in the issue slot takes the port; retry from PEND.
                if (!cg_cs)
                    state_next = ST_IDLE;
                else if (vreq)
                    state_next = ST_PEND;
                else if (wr_reg)
                    state_next = ST_DONE;
                else
                    state_next = ST_RDATA;
            end
            ST_RDATA: begin
                if (!cg_cs) begin
                    state_next = ST_IDLE;
                end else begin
                    do_next    = lane_sel(ram_q, plane_reg);
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!cg_cs) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        starve_next = starve_reg;
        if (state_next == ST_IDLE || state_next == ST_DONE)
            starve_next = 1'b0;
        else if (cnt_next == CNT_W'(STARVE_MAX))
            starve_next = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            do_reg     <= 8'hFF;
            cnt_reg    <= '0;
            starve_reg <= 1'b0;
            plane_reg  <= PLANE_NONE;
            wr_reg     <= 1'b0;
            caddr_reg  <= '0;
            di_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            do_reg     <= do_next;
            cnt_reg    <= cnt_next;
            starve_reg <= starve_next;
            if (state_reg == ST_IDLE && cpu_req) begin
                plane_reg <= plane_t'(a_plane);
                wr_reg    <= wr;
                caddr_reg <= caddr;
                di_reg    <= di;
            end
        end
    end

    // Issue is gated by chip select so an abort in the issue cycle never writes.
    assign issue      = (state_reg == ST_ISSUE) & cg_cs;
    assign issue_we   = wr_reg ? plane_we(plane_reg) : WE_NONE;
    assign issue_addr = caddr_reg;
    assign issue_data = di_reg;
    assign cpu_do     = do_reg;
    assign starve     = starve_reg;
    assign cg_wait_n  = ~(cg_cs & (state_reg != ST_DONE) & ~rst);

endmodule

// File: rtl/pcg_access_arbiter.sv
// Arbitrates the single-ported three-plane PCG RAM between the never-stalled
// video fetch path and the Z80 I/O path.
module pcg_access_arbiter
    import pcg_arb_pkg::*;
#(
    parameter int STARVE_MAX = 64,
    parameter int CNT_W      = 7
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_CG_CS,
    input  logic        I_RD,
    input  logic        I_WR,
    input  logic [15:0] I_A,
    input  logic [10:0] I_CADDR,
    input  logic [7:0]  I_DI,
    output logic [7:0]  O_DO,
    output logic        O_CG_WAIT_n,
    output logic        O_STARVE,
    input  logic        I_VREQ,
    input  logic [10:0] I_VADDR,
    output logic        O_VVALID,
    output logic [23:0] O_VDATA,
    output logic [10:0] O_RAM_A,
    output logic [2:0]  O_RAM_WE,
    output logic [7:0]  O_RAM_D,
    input  logic [23:0] I_RAM_Q
);

    logic        cpu_issue;
    logic [2:0]  cpu_we;
    logic [10:0] cpu_addr;
    logic        vvalid_reg;
    logic        unused_a_bits;

    assign unused_a_bits = &{1'b0, I_A[15:10], I_A[7:0]};

    pcg_cpu_fsm #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_cpu_fsm (
        .clk        (I_CLK),
        .rst        (I_RESET),
        .cg_cs      (I_CG_CS),
        .rd         (I_RD),
        .wr         (I_WR),
        .a_plane    (I_A[9:8]),
        .caddr      (I_CADDR),
        .di         (I_DI),
        .vreq       (I_VREQ),
        .ram_q      (I_RAM_Q),
        .cpu_do     (O_DO),
        .cg_wait_n  (O_CG_WAIT_n),
        .starve     (O_STARVE),
        .issue      (cpu_issue),
        .issue_we   (cpu_we),
        .issue_addr (cpu_addr),
        .issue_data (O_RAM_D)
    );

    // Video owns the port outright whenever it requests.
    assign O_RAM_A = I_VREQ ? I_VADDR : (cpu_issue ? cpu_addr : 11'd0);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_we
            assign O_RAM_WE[gi] = ~I_VREQ & cpu_issue & cpu_we[gi];
        end
    endgenerate

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET)
            vvalid_reg <= 1'b0;
        else
            vvalid_reg <= I_VREQ;
    end

    assign O_VVALID = vvalid_reg;
    assign O_VDATA  = I_RAM_Q;

endmodule

// File: tb/tb_pcg_access_arbiter.sv
// Directed bench for pcg_access_arbiter: CPU reads/writes per plane, video
// collisions, starvation flag, plane-00 accesses, abort and reset mid-access.
module tb_pcg_access_arbiter;

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic        I_CG_CS, I_RD, I_WR;
    logic [15:0] I_A;
    logic [10:0] I_CADDR;
    logic [7:0]  I_DI;
    logic [7:0]  O_DO;
    logic        O_CG_WAIT_n, O_STARVE;
    logic        I_VREQ;
    logic [10:0] I_VADDR;
    logic        O_VVALID;
    logic [23:0] O_VDATA;
    logic [10:0] O_RAM_A;
    logic [2:0]  O_RAM_WE;
    logic [7:0]  O_RAM_D;
    logic [23:0] I_RAM_Q;

    localparam logic [23:0] RAM_WORD = 24'h3C5A69;   // G=3C R=5A B=69
    localparam logic [10:0] VADDR    = 11'h123;

    int n_chk = 0;
    int n_bad = 0;

    pcg_access_arbiter #(.STARVE_MAX(64), .CNT_W(7)) dut (
        .I_CLK       (I_CLK),
        .I_RESET     (I_RESET),
        .I_CG_CS     (I_CG_CS),
        .I_RD        (I_RD),
        .I_WR        (I_WR),
        .I_A         (I_A),
        .I_CADDR     (I_CADDR),
        .I_DI        (I_DI),
        .O_DO        (O_DO),
        .O_CG_WAIT_n (O_CG_WAIT_n),
        .O_STARVE    (O_STARVE),
        .I_VREQ      (I_VREQ),
        .I_VADDR     (I_VADDR),
        .O_VVALID    (O_VVALID),
        .O_VDATA     (O_VDATA),
        .O_RAM_A     (O_RAM_A),
        .O_RAM_WE    (O_RAM_WE),
        .O_RAM_D     (O_RAM_D),
        .I_RAM_Q     (I_RAM_Q)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access of ncyc cycles; cycle 0 is the request cycle. Operands are
    // scrambled after cycle 0 to show they were latched.
    task automatic run_access(
        input  string       name,
        input  logic [15:0] a,
        input  logic [10:0] ca,
        input  logic [7:0]  d,
        input  bit          is_wr,
        input  logic [2:0]  exp_we,
        input  int          v_lo,
        input  int          v_hi,
        input  int          cs_drop,
        input  int          ncyc,
        output int          wait_low,
        output int          we_cnt,
        output int          we_first,
        output int          vv_cnt,
        output int          st_first,
        output int          st_last
    );
        wait_low = 0; we_cnt = 0; we_first = -1; vv_cnt = 0; st_first = -1; st_last = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge I_CLK); #1;
            I_CG_CS = (c < cs_drop);
            I_RD    = !is_wr && (c < cs_drop);
            I_WR    = is_wr && (c < cs_drop);
            I_A     = (c == 0) ? a  : (a ^ 16'h0300);
            I_CADDR = (c == 0) ? ca : ~ca;
            I_DI    = (c == 0) ? d  : ~d;
            I_VREQ  = (c >= v_lo) && (c < v_hi);
            @(negedge I_CLK);
            if (!O_CG_WAIT_n) wait_low++;
            if (O_VVALID) begin
                vv_cnt++;
                chk("vdata", O_VDATA, RAM_WORD);
            end
            if (I_VREQ) begin
                chk("vmux_a", O_RAM_A, VADDR);
                chk("vmux_we", O_RAM_WE, 3'b000);
            end
            if (O_RAM_WE != 3'b000) begin
                we_cnt++;
                if (we_first < 0) we_first = c;
                chk("ram_we", O_RAM_WE, exp_we);
                chk("ram_a", O_RAM_A, ca);
                chk("ram_d", O_RAM_D, d);
            end
            if (O_STARVE) begin
                if (st_first < 0) st_first = c;
                st_last = c;
            end
        end
        @(posedge I_CLK); #1;
        I_CG_CS = 1'b0; I_RD = 1'b0; I_WR = 1'b0; I_VREQ = 1'b0;
        @(negedge I_CLK);
        chk("idle_wait", O_CG_WAIT_n, 1'b1);
        $display("txn %s a=%h wait_low=%0d we_cnt=%0d we_first=%0d vvalid=%0d do=%h",
                 name, a, wait_low, we_cnt, we_first, vv_cnt, O_DO);
    endtask

    int wl, wc, wf, vc, sf, sl;
    int rst_we;

    initial begin
        I_RESET = 1'b1; I_CG_CS = 1'b0; I_RD = 1'b0; I_WR = 1'b0;
        I_A = '0; I_CADDR = '0; I_DI = '0; I_VREQ = 1'b0;
        I_VADDR = VADDR; I_RAM_Q = RAM_WORD;
        repeat (2) @(posedge I_CLK);
        #1 I_RESET = 1'b0;
        @(negedge I_CLK);
        chk("rst_do", O_DO, 8'hFF);
        chk("rst_vvalid", O_VVALID, 1'b0);
        chk("rst_starve", O_STARVE, 1'b0);
        chk("rst_wait", O_CG_WAIT_n, 1'b1);
        chk("rst_we", O_RAM_WE, 3'b000);
        chk("rst_a", O_RAM_A, 11'd0);

        // Write blue, video idle: IDLE, PEND, ISSUE(cycle 2), DONE.
        run_access("wr_b", 16'h1500, 11'h041, 8'hA5, 1'b1, 3'b001, 0, 0, 99, 6, wl, wc, wf, vc, sf, sl);
        chk("wr_b_wait", wl, 3);
        chk("wr_b_wecnt", wc, 1);
        chk("wr_b_wecyc", wf, 2);

        // Read green: IDLE, PEND, ISSUE, RDATA, DONE.
        run_access("rd_g", 16'h1700, 11'h2A3, 8'h00, 1'b0, 3'b000, 0, 0, 99, 6, wl, wc, wf, vc, sf, sl);
        chk("rd_g_wait", wl, 4);
        chk("rd_g_wecnt", wc, 0);
        chk("rd_g_do", O_DO, 8'h3C);

        run_access("rd_r", 16'h0600, 11'h010, 8'h00, 1'b0, 3'b000, 0, 0, 99, 6, wl, wc, wf, vc, sf, sl);
        chk("rd_r_do", O_DO, 8'h5A);

        // Video held for cycles 0..4: PEND 1..5, ISSUE 6.
        run_access("coll", 16'h1600, 11'h7FF, 8'h3C, 1'b1, 3'b010, 0, 5, 99, 9, wl, wc, wf, vc, sf, sl);
        chk("coll_wecyc", wf, 6);
        chk("coll_wecnt", wc, 1);
        chk("coll_vvalid", vc, 5);
        chk("coll_wait", wl, 7);
        chk("coll_starve", sf, -1);

        // Video only in the ISSUE slot (cycle 2): retry issues at cycle 4.
        run_access("iss_coll", 16'h0300, 11'h155, 8'h5A, 1'b1, 3'b100, 2, 3, 99, 7, wl, wc, wf, vc, sf, sl);
        chk("isscoll_wecyc", wf, 4);
        chk("isscoll_wecnt", wc, 1);
        chk("isscoll_wait", wl, 5);

        // Starvation: 69 blocked PEND cycles; flag visible after the 64th, clears on DONE.
        run_access("starve", 16'h1500, 11'h3FF, 8'hC3, 1'b1, 3'b001, 0, 70, 99, 75, wl, wc, wf, vc, sf, sl);
        chk("starve_first", sf, 65);
        chk("starve_last", sl, 71);
        chk("starve_wecyc", wf, 71);
        chk("starve_vvalid", vc, 70);
        chk("starve_end", O_STARVE, 1'b0);

        run_access("rd_b", 16'h0100, 11'h000, 8'h00, 1'b0, 3'b000, 0, 0, 99, 6, wl, wc, wf, vc, sf, sl);
        chk("rd_b_do", O_DO, 8'h69);

        // Plane 00: straight to DONE, no RAM cycle.
        run_access("rd_p0", 16'h1400, 11'h099, 8'h00, 1'b0, 3'b000, 0, 0, 99, 4, wl, wc, wf, vc, sf, sl);
        chk("rd_p0_do", O_DO, 8'hFF);
        chk("rd_p0_wait", wl, 1);
        chk("rd_p0_wecnt", wc, 0);

        run_access("wr_p0", 16'h0000, 11'h099, 8'h77, 1'b1, 3'b000, 0, 0, 99, 4, wl, wc, wf, vc, sf, sl);
        chk("wr_p0_wait", wl, 1);
        chk("wr_p0_wecnt", wc, 0);

        // Abort in PEND: CS drops at cycle 2, no write later when video frees up.
        run_access("abort", 16'h1500, 11'h0AA, 8'hEE, 1'b1, 3'b001, 0, 2, 2, 6, wl, wc, wf, vc, sf, sl);
        chk("abort_wecnt", wc, 0);
        chk("abort_wait", wl, 2);
        chk("abort_do", O_DO, 8'hFF);

        run_access("rd_after", 16'h1600, 11'h011, 8'h00, 1'b0, 3'b000, 0, 0, 99, 6, wl, wc, wf, vc, sf, sl);
        chk("rd_after_wait", wl, 4);
        chk("rd_after_do", O_DO, 8'h5A);

        // Reset while in PEND with CS still held.
        @(posedge I_CLK); #1;
        I_CG_CS = 1'b1; I_WR = 1'b1; I_A = 16'h1500; I_CADDR = 11'h055; I_DI = 8'h11; I_VREQ = 1'b1;
        @(posedge I_CLK); #1;
        @(negedge I_CLK);
        chk("pend_wait", O_CG_WAIT_n, 1'b0);
        I_RESET = 1'b1; I_VREQ = 1'b0;
        #1;
        chk("rst_mid_wait", O_CG_WAIT_n, 1'b1);
        rst_we = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge I_CLK);
            if (O_RAM_WE != 3'b000) rst_we++;
        end
        I_CG_CS = 1'b0; I_WR = 1'b0;
        @(posedge I_CLK); #1;
        I_RESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge I_CLK);
            if (O_RAM_WE != 3'b000) rst_we++;
        end
        chk("rst_mid_wecnt", rst_we, 0);
        chk("rst_mid_do", O_DO, 8'hFF);
        chk("rst_mid_idle", O_CG_WAIT_n, 1'b1);
        $display("txn rst_mid we_cnt=%0d do=%h", rst_we, O_DO);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
